// File: rtl/hamming_rx_deserializer.sv
// Beat-to-codeword assembler ahead of the 2-D Hamming decoder.
// Define HAMMING_DESER_MSB_FIRST_EN to place the first beat in the MSBs.
module hamming_rx_deserializer #(
    parameter int CW_W   = 105,
    parameter int LANE_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [LANE_W-1:0] s_data,
    input  logic              s_sof,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW_W-1:0]   m_codeword,
    output logic [7:0]        frame_err_cnt
);
    localparam int BEATS = CW_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SH_W  = $clog2(CW_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n, idx;
    logic [CW_W-1:0]   frame_q, frame_n, merged, cw_n;
    logic [CW_W-1:0]   lane, mask;
    logic [SH_W-1:0]   sh;
    logic [7:0]        err_n;
    logic              valid_n, acc, wr, last, out_free;

    assign s_ready  = (state != HOLD);
    assign acc      = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    assign lane     = CW_W'(s_data);
    assign mask     = CW_W'({LANE_W{1'b1}});

    // An sof beat always restarts at beat 0, in IDLE or as an abort.
    assign idx  = (state == COLLECT && !s_sof) ? count : '0;
    assign wr   = acc && (s_sof || state == COLLECT);
    assign last = wr && (idx == CNT_W'(BEATS - 1));

`ifdef HAMMING_DESER_MSB_FIRST_EN
    assign sh = SH_W'(CW_W - LANE_W) - SH_W'(idx) * SH_W'(LANE_W);
`else
    assign sh = SH_W'(idx) * SH_W'(LANE_W);
`endif

    assign merged = (frame_q & ~(mask << sh)) | (lane << sh);

    always_comb begin
        state_n = state;
        count_n = count;
        frame_n = frame_q;
        cw_n    = m_codeword;
        valid_n = m_valid;
        err_n   = frame_err_cnt;
        if (m_valid && m_ready) begin
            valid_n = 1'b0;
        end
        unique case (state)
            IDLE, COLLECT: begin
                if (acc && s_sof && state == COLLECT && frame_err_cnt != 8'hFF) begin
                    err_n = frame_err_cnt + 8'd1;
                end
                if (last) begin
                    frame_n = merged;
                    count_n = '0;
                    if (out_free) begin
                        cw_n    = merged;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = HOLD;
                    end
                end else if (wr) begin
                    frame_n = merged;
                    count_n = idx + CNT_W'(1);
                    state_n = COLLECT;
                end
            end
            HOLD: begin
                // Output register is full here, so m_valid is known high.
                if (m_valid && m_ready) begin
                    cw_n    = frame_q;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            frame_q       <= '0;
            m_codeword    <= '0;
            m_valid       <= 1'b0;
            frame_err_cnt <= 8'd0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            frame_q       <= frame_n;
            m_codeword    <= cw_n;
            m_valid       <= valid_n;
            frame_err_cnt <= err_n;
        end
    end
endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Bench for hamming_rx_deserializer: two-entry word queue model plus
// directed literal checks; honours HAMMING_DESER_MSB_FIRST_EN.
module tb_hamming_rx_deserializer;
    localparam int CW = 105;
    localparam int LW = 7;
    localparam int NB = CW / LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic [LW-1:0] s_data = '0;
    logic          m_ready = 1'b1;
    logic          s_ready;
    logic          m_valid;
    logic [CW-1:0] m_codeword;
    logic [7:0]    frame_err_cnt;

    always #5 clk = ~clk;

    hamming_rx_deserializer #(.CW_W(CW), .LANE_W(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_sof(s_sof),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_codeword(m_codeword),
        .frame_err_cnt(frame_err_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: words completed but not yet taken by the decoder, at most two.
    logic [CW-1:0] exp_q[$];
    logic [LW-1:0] cur[NB];
    int            ncur = 0;
    int            exp_err = 0;
    int            cyc = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit            take;
        logic [CW-1:0] w;
        if (!rst_n) begin
            exp_q.delete();
            ncur = 0;
            exp_err = 0;
        end else begin
            cyc++;
            take = s_valid && (exp_q.size() < 2);
            if (m_ready && exp_q.size() > 0) exp_q.delete(0);
            if (take) begin
                if (s_sof) begin
                    if (ncur != 0 && exp_err < 255) exp_err++;
                    cur[0] = s_data;
                    ncur = 1;
                end else if (ncur != 0) begin
                    cur[ncur] = s_data;
                    ncur++;
                end
                if (ncur == NB) begin
                    w = '0;
                    for (int k = 0; k < NB; k++) begin
`ifdef HAMMING_DESER_MSB_FIRST_EN
                        w[CW-1-k*LW -: LW] = cur[k];
`else
                        w[k*LW +: LW] = cur[k];
`endif
                    end
                    exp_q.push_back(w);
                    ncur = 0;
                end
            end
        end
    end

    int delivered = 0;
    int last_hs = 0;
    int hs_gap = 0;
    int ready_low = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("s_ready", CW'(s_ready), CW'(exp_q.size() < 2));
            chk("m_valid", CW'(m_valid), CW'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("m_codeword", m_codeword, exp_q[0]);
            chk("frame_err_cnt", CW'(frame_err_cnt), CW'(exp_err));
            if (m_valid && m_ready) begin
                delivered++;
                hs_gap = cyc - last_hs;
                last_hs = cyc;
            end
            if (!s_ready) ready_low++;
        end
    end

    task automatic send(input logic sof, input logic [LW-1:0] d);
        s_valid = 1'b1;
        s_sof = sof;
        s_data = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < NB; k++) send(k == 0, LW'(base + k));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int d0;
    int r0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", CW'(m_valid), '0);
        chk("rst_s_ready", CW'(s_ready), CW'(1));
        chk("rst_codeword", m_codeword, '0);
        chk("rst_err", CW'(frame_err_cnt), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        for (int k = 0; k < NB - 1; k++) send(k == 0, LW'(k + 1));
        chk("t1_valid_early", CW'(m_valid), '0);
        send(1'b0, 7'd15);
        chk("t1_valid", CW'(m_valid), CW'(1));
`ifdef HAMMING_DESER_MSB_FIRST_EN
        chk("t1_top", CW'(m_codeword[104:98]), CW'(1));
        chk("t1_bot", CW'(m_codeword[6:0]), CW'(15));
`else
        chk("t1_bot", CW'(m_codeword[6:0]), CW'(1));
        chk("t1_top", CW'(m_codeword[104:98]), CW'(15));
`endif
        chk("t1_err", CW'(frame_err_cnt), '0);
        idle(3);

        d0 = delivered;
        r0 = ready_low;
        send_frame(20);
        send_frame(40);
        idle(3);
        chk("t2_words", CW'(delivered - d0), CW'(2));
        chk("t2_gap", CW'(hs_gap), CW'(15));
        chk("t2_ready_low", CW'(ready_low - r0), '0);

        m_ready = 1'b0;
        send_frame(60);
        send_frame(80);
        chk("t3_hold_ready", CW'(s_ready), '0);
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        chk("t3_ready_back", CW'(s_ready), CW'(1));
        chk("t3_valid", CW'(m_valid), CW'(1));
`ifdef HAMMING_DESER_MSB_FIRST_EN
        chk("t3_word", CW'(m_codeword[104:98]), CW'(80));
`else
        chk("t3_word", CW'(m_codeword[6:0]), CW'(80));
`endif
        m_ready = 1'b1;
        idle(3);

        d0 = delivered;
        send(1'b1, 7'd5);
        for (int k = 0; k < 4; k++) send(1'b0, LW'(6 + k));
        send_frame(100);
        idle(3);
        chk("t4_err", CW'(frame_err_cnt), CW'(1));
        chk("t4_words", CW'(delivered - d0), CW'(1));

        d0 = delivered;
        for (int k = 0; k < 3; k++) send(1'b0, LW'(k + 1));
        send_frame(110);
        idle(3);
        chk("t5_words", CW'(delivered - d0), CW'(1));
        for (int i = 0; i < 301; i++) send(1'b1, LW'(i));
        chk("t5_sat", CW'(frame_err_cnt), CW'(255));

        for (int k = 0; k < 8; k++) send(k == 0, LW'(10 + k));
        rst_n = 1'b0;
        #2;
        chk("t6_m_valid", CW'(m_valid), '0);
        chk("t6_s_ready", CW'(s_ready), CW'(1));
        chk("t6_codeword", m_codeword, '0);
        chk("t6_err", CW'(frame_err_cnt), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        d0 = delivered;
        send_frame(120);
        idle(3);
        chk("t6_words", CW'(delivered - d0), CW'(1));
        chk("t6_err_after", CW'(frame_err_cnt), '0);
        chk("drained", CW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
